// File: rtl/conv_serializer_if.sv
// Handshake/stream bundle between a word producer, the serializer and the pooling stage.
interface conv_serializer_if #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*DATA_W-1:0]   in_pixels;
   logic                      hold;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_pixel;
   logic                      out_last;
   logic                      busy;

   modport master (
      output in_valid, in_pixels, hold,
      input  in_ready, out_valid, out_pixel, out_last, busy
   );

   modport slave (
      input  in_valid, in_pixels, hold,
      output in_ready, out_valid, out_pixel, out_last, busy
   );
endinterface

// File: rtl/conv_serializer.sv
// Word-to-pixel serializer: 2-entry word buffer, lanes emitted one per clock, lane 0 first.
// state  | meaning
// IDLE   | buffer empty, nothing to emit
// EMIT   | at least one word buffered; a lane is emitted on each edge with hold low
module conv_serializer #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   conv_serializer_if.slave   bus
);
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   logic [LANES*DATA_W-1:0] mem_q [2];
   logic                    wr_ptr_q, rd_ptr_q;
   logic [1:0]              count_q, count_d;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [0:0]              state_q, state_d;
   logic                    out_valid_q, out_last_q;
   logic [DATA_W-1:0]       out_pixel_q;

   logic                    in_ready;
   logic                    push, emit, pop;
   logic [LANES*DATA_W-1:0] head;
   logic [DATA_W-1:0]       head_pixel;

   assign in_ready   = !rst_i && (count_q != 2'd2);
   assign push       = bus.in_valid && in_ready;
   assign emit       = (state_q == S_EMIT) && !bus.hold;
   assign pop        = emit && (lane_q == LAST_LANE);
   assign head       = mem_q[rd_ptr_q];
   assign head_pixel = head[int'(lane_q)*DATA_W +: DATA_W];

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      state_d = (count_d != 2'd0) ? S_EMIT : S_IDLE;
      lane_d  = lane_q;
      if (emit) lane_d = pop ? '0 : lane_q + LANE_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         lane_q      <= '0;
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_pixel_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= bus.in_pixels;
            wr_ptr_q        <= !wr_ptr_q;
         end
         if (pop) rd_ptr_q <= !rd_ptr_q;
         count_q     <= count_d;
         lane_q      <= lane_d;
         state_q     <= state_d;
         out_valid_q <= emit;
         out_last_q  <= pop;
         // Sample holds its value through stalls; downstream only looks when out_valid is high.
         if (emit) out_pixel_q <= head_pixel;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_pixel = out_pixel_q;
   assign bus.busy      = (count_q != 2'd0);
endmodule

// File: tb/tb_conv_serializer.sv
// Self-checking bench for conv_serializer: fixed vector table, corner sequences and random traffic vs a pixel-queue model.
module tb_conv_serializer;
   localparam int DATA_W = 8;
   localparam int LANES  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   conv_serializer_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();
   conv_serializer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: a flat queue of pixels still to be emitted; a word occupies
   // the buffer until its last lane has been emitted.
   logic [DATA_W-1:0] q_pix[$];
   bit                q_last[$];
   logic              m_valid = 1'b0;
   logic              m_last  = 1'b0;
   logic [DATA_W-1:0] m_pix   = '0;

   function automatic int m_count();
      return (q_pix.size() + LANES - 1) / LANES;
   endfunction

   task automatic model_reset();
      q_pix.delete();
      q_last.delete();
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_pix   = '0;
   endtask

   task automatic model_edge(input logic v, input logic [LANES*DATA_W-1:0] w, input logic h);
      bit do_emit, do_push;
      do_emit = (q_pix.size() > 0) && !h;
      do_push = v && (m_count() < 2);
      if (do_emit) begin
         m_pix   = q_pix.pop_front();
         m_last  = q_last.pop_front();
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
         m_last  = 1'b0;
      end
      if (do_push)
         for (int i = 0; i < LANES; i++) begin
            q_pix.push_back(w[i*DATA_W +: DATA_W]);
            q_last.push_back(i == LANES - 1);
         end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_model();
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_last",  32'(bus.out_last),  32'(m_last));
      chk("out_pixel", 32'(bus.out_pixel), 32'(m_pix));
      chk("busy",      32'(bus.busy),      32'(!rst && m_count() != 0));
      chk("in_ready",  32'(bus.in_ready),  32'(!rst && m_count() < 2));
   endtask

   task automatic step();
      logic v, h;
      logic [LANES*DATA_W-1:0] w;
      v = bus.in_valid;
      w = bus.in_pixels;
      h = bus.hold;
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else     model_edge(v, w, h);
      #1;
      chk_model();
   endtask

   typedef struct {
      logic                    v;
      logic [LANES*DATA_W-1:0] w;
      logic                    h;
      logic                    ev;
      logic [DATA_W-1:0]       ep;
      logic                    el;
      logic                    eb;
   } vec_t;

   vec_t tbl[15];

   initial begin
      logic [LANES*DATA_W-1:0] words[3];
      int idx, run, best, acc3, last1;
      bit acc;

      // single word, then hold mid-word
      tbl[0]  = '{1'b1, 32'h04FD7F80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'hFD, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h04, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 8'h04, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 32'h44332211, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h22, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h22, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h22, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h22, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h33, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h44, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'h44, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_pixels = '0;
      bus.hold      = 1'b0;
      model_reset();

      // reset held, then released
      step();
      step();
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 15; i++) begin
         bus.in_valid  = tbl[i].v;
         bus.in_pixels = tbl[i].w;
         bus.hold      = tbl[i].h;
         step();
         chk("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].ev));
         chk("tbl_pixel", 32'(bus.out_pixel), 32'(tbl[i].ep));
         chk("tbl_last",  32'(bus.out_last),  32'(tbl[i].el));
         chk("tbl_busy",  32'(bus.busy),      32'(tbl[i].eb));
      end

      // back-to-back: three words with in_valid held high
      words[0] = 32'hA3A2A1A0;
      words[1] = 32'hB3B2B1B0;
      words[2] = 32'hC3C2C1C0;
      idx = 0; run = 0; best = 0; acc3 = -1; last1 = -1;
      bus.in_valid  = 1'b1;
      bus.in_pixels = words[0];
      for (int c = 0; c < 20; c++) begin
         acc = bus.in_valid && bus.in_ready;
         step();
         if (acc) begin
            if (idx == 2) acc3 = cyc;
            idx++;
         end
         if (idx >= 3) bus.in_valid = 1'b0;
         else          bus.in_pixels = words[idx];
         if (bus.out_last && last1 < 0) last1 = cyc;
         if (bus.out_valid) run++;
         else run = 0;
         if (run > best) best = run;
      end
      chk("b2b_run", 32'(best), 32'd12);
      chk("b2b_accept3", 32'(acc3 - last1), 32'd1);

      // push at the same edge that pops the only buffered word
      bus.in_valid  = 1'b1;
      bus.in_pixels = 32'h5D5C5B5A;
      step();
      bus.in_valid = 1'b0;
      step(); step(); step();
      bus.in_valid  = 1'b1;
      bus.in_pixels = 32'h6D6C6B6A;
      step();
      chk("sim_last",  32'(bus.out_last), 32'd1);
      chk("sim_busy",  32'(bus.busy),     32'd1);
      chk("sim_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      step();
      chk("sim_nogap", 32'({bus.out_valid, bus.out_pixel}), 32'h16A);
      step(); step(); step(); step();

      // async reset mid-word with a second word buffered
      bus.in_valid  = 1'b1;
      bus.in_pixels = 32'h73727170;
      step();
      bus.in_pixels = 32'h83828180;
      step();
      bus.in_valid = 1'b0;
      step(); step();
      chk("pre_rst_lane2", 32'(bus.out_pixel), 32'h72);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_out", 32'({bus.out_valid, bus.out_last, bus.out_pixel, bus.busy, bus.in_ready}), 32'd0);
      model_reset();
      step(); step();
      rst = 1'b0;
      #1;
      chk("ready_after_rst2", 32'(bus.in_ready), 32'd1);
      step(); step();
      bus.in_valid  = 1'b1;
      bus.in_pixels = 32'h04030201;
      step();
      bus.in_valid = 1'b0;
      step();
      chk("rst_new_lane0", 32'({bus.out_valid, bus.out_pixel}), 32'h101);
      step(); step(); step(); step();

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_pixels = $urandom;
         bus.hold      = ($urandom_range(0, 4) == 0);
         step();
      end
      bus.in_valid = 1'b0;
      bus.hold     = 1'b0;
      for (int c = 0; c < 10; c++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/conv_serializer.md
# conv_serializer

Streams binarized feature words back into the serial 8-bit pixel format consumed by the pooling stage. It accepts one LANES-wide word per valid/ready handshake into a 2-entry buffer, then emits the lanes one per clock, lane 0 first. A `out_last` strobe marks the final lane of each word, which matches the enable timing the pooling stage expects. A `hold` input stalls emission without losing data.

## Interface
- `DATA_W`, default 8: pixel width, two's complement.
- `LANES`, default 4: pixels per word; emission order lane 0 → lane LANES-1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_pixels` holds a word.
- `in_ready`  out  1  buffer can accept; combinational, equals `!rst && (count < 2)`.
- `in_pixels`  in  LANES×DATA_W  packed word; `[i]` is lane i.
- `hold`  in  1  when high, emission pauses.
- `out_valid`  out  1  `out_pixel` is a new sample this cycle.
- `out_pixel`  out  DATA_W  current sample.
- `out_last`  out  1  high with the sample of lane LANES-1.
- `busy`  out  1  buffer non-empty or a word is mid-emission.

## Operation
- **Buffer.** 2-entry FIFO of words, with `count` from 0 to 2.
  - A push occurs on `in_valid && in_ready`.
  - A pop occurs when the last lane of the head word is loaded into the output registers.
  - A simultaneous push and pop keeps `count` unchanged.
  - When `count` is 2, a push and pop in the same cycle is impossible, because `in_ready` is 0 in that state.
- **Lane counter.** `lane` runs from 0 to LANES-1 and indexes the head word.
- **FSM states.**
  - IDLE: `count` is 0.
  - EMIT: `count` > 0.
- **Emission rule.** At each rising edge, emission is allowed when the FSM is in EMIT and `hold` is 0. When allowed:
  - `out_pixel` loads `head[lane]`.
  - `out_valid` is set to 1.
  - `out_last` is set to `(lane == LANES-1)`.
  - If `lane == LANES-1`, then `lane` returns to 0 and the head is popped. Otherwise `lane` increments.
- **No emission.** At an edge where emission is not allowed, `out_valid` and `out_last` are set to 0. `out_pixel` retains its value and `lane` is unchanged.
- **Hold.** `hold` only affects emission; pushes continue normally while `hold` is high. No sample is duplicated or dropped.
- **IDLE → EMIT.** This transition occurs on the first push. EMIT returns to IDLE when the final pop empties the buffer with no push at the same edge.
- **Data handling.** Pixels pass through unmodified; there is no arithmetic or sign change. `busy` is `count != 0`.

## Timing
- **Reset values.** While `rst` is high, and immediately on its assertion:
  - `out_valid` = 0, `out_last` = 0, `out_pixel` = 0, `busy` = 0, `in_ready` = 0.
  - `count` = 0, `lane` = 0, FSM in IDLE.
- **Reset mid-word.** Any partial word and all buffered words are discarded.
- **Latency.** A word accepted at edge k into an empty block has its lane 0 on `out_pixel`, with `out_valid` high, after edge k+1. Lane LANES-1 appears after edge k+LANES, with `out_last` high.
- **Throughput.** The steady state is one word per LANES cycles. With `in_valid` held high and `hold` low, `out_valid` stays high continuously across word boundaries, with no bubble.
- **Backpressure.** `in_ready` falls in the cycle after `count` reaches 2. It rises in the cycle after the pop that frees an entry.
- **`hold` timing.** `hold` is sampled at the edge. If `hold` is high at edge n, `out_valid` is 0 in cycle n..n+1. The pending lane is emitted at the first edge where `hold` is low.
- **Downstream sampling.** The downstream stage samples `out_pixel` and `out_last` in every cycle in which `out_valid` is high.

## Test plan
1. **Reset.** Assert `rst` asynchronously mid-cycle.
   - Required: all outputs go to 0 at once.
   - Required: `in_ready` = 1 in the first cycle after `rst` is released.
2. **Single word.** Push lanes 0..3 = 0x80, 0x7F, 0xFD, 0x04 at edge k.
   - Required: `out_pixel` = 0x80, 0x7F, 0xFD, 0x04 after edges k+1..k+4.
   - Required: `out_last` is high only with 0x04.
   - Required: `out_valid` = 0 after edge k+5, and `busy` = 0.
3. **Back-to-back words.** Push 3 words with `in_valid` held high.
   - Required: 12 consecutive `out_valid` cycles, in order.
   - Required: `in_ready` low while `count` = 2.
   - Required: the third word is accepted in the cycle after the first word's final pop.
4. **Hold mid-word.** Assert `hold` for 3 edges after lane 1 of the word 0x11, 0x22, 0x33, 0x44.
   - Required: `out_valid` is low for 3 cycles.
   - Required: 0x33, then 0x44 with `out_last` high; 0x22 is never repeated.
5. **Reset mid-operation.** Assert `rst` after lane 2, with a second word also buffered.
   - Required: no further output after reset.
   - Required: after release, a new word 0x01, 0x02, 0x03, 0x04 emits from lane 0 with latency 1.
6. **Simultaneous push and pop.** Push at the same edge that pops the last lane of the head word while `count` = 1.
   - Required: `count` stays 1.
   - Required: the new word's lane 0 follows the previous `out_last` with no gap.
